// File: rtl/router_pkt_tx_if.sv
// Router input-port link: upstream payload stream, send request and the byte channel to the router.
// Macro ROUTER_TX_PARITY_INJ_EN adds the inj_parity_err request bit.
interface router_pkt_tx_if #(
  parameter int unsigned DATA_W = 8
);
  logic              start;
  logic [1:0]        dest;
  logic [5:0]        len;
  logic              abort;
  logic [DATA_W-1:0] pl_data;
  logic              pl_valid;
  logic              pl_ready;
  logic              busy;
  logic [DATA_W-1:0] data_out;
  logic              pkt_valid;
  logic              tx_busy;
  logic              done;
  logic              err;
`ifdef ROUTER_TX_PARITY_INJ_EN
  logic              inj_parity_err;
`endif

  modport master (
`ifdef ROUTER_TX_PARITY_INJ_EN
    input  inj_parity_err,
`endif
    input  start, dest, len, abort, pl_data, pl_valid, busy,
    output pl_ready, data_out, pkt_valid, tx_busy, done, err
  );

  modport slave (
`ifdef ROUTER_TX_PARITY_INJ_EN
    output inj_parity_err,
`endif
    output start, dest, len, abort, pl_data, pl_valid, busy,
    input  pl_ready, data_out, pkt_valid, tx_busy, done, err
  );
endinterface

// File: rtl/router_pkt_tx.sv
// Packet transmitter: buffers a whole payload, then sends header, payload and parity to the router.
// Optional macro ROUTER_TX_PARITY_INJ_EN: deliberately corrupt the parity byte on request.
module router_pkt_tx #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned MAX_LEN = 63
) (
  input logic             clk,
  input logic             rst,
  router_pkt_tx_if.master bus
);
  localparam int unsigned LenW = 6;

  typedef enum logic [2:0] {StIdle, StLoad, StHeader, StPayload, StParity, StDone} state_e;

  state_e            state_q, state_d;
  logic [1:0]        dest_q, dest_d;
  logic [LenW-1:0]   len_q, len_d;
  logic [LenW-1:0]   wr_q, wr_d;
  logic [LenW-1:0]   rd_q, rd_d;
  logic [DATA_W-1:0] par_q, par_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] mem_q [MAX_LEN];
  logic [7:0]        hdr;
  logic [LenW-1:0]   last_idx;
  logic [DATA_W-1:0] par_out;
  logic [DATA_W-1:0] data_out;

  assign hdr      = {len_q, dest_q};
  assign last_idx = len_q - 6'd1;

`ifdef ROUTER_TX_PARITY_INJ_EN
  logic inj_q, inj_d;
  assign par_out = par_q ^ DATA_W'(inj_q);
`else
  assign par_out = par_q;
`endif

  always_comb begin
    state_d = state_q;
    dest_d  = dest_q;
    len_d   = len_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    par_d   = par_q;
    err_d   = 1'b0;
`ifdef ROUTER_TX_PARITY_INJ_EN
    inj_d   = inj_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (bus.dest != 2'd3 && bus.len != '0) begin
            dest_d  = bus.dest;
            len_d   = bus.len;
            wr_d    = '0;
            state_d = StLoad;
`ifdef ROUTER_TX_PARITY_INJ_EN
            inj_d   = bus.inj_parity_err;
`endif
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StLoad: begin
        // Index stops at len-1; the last write moves straight on to the header.
        if (bus.pl_valid) begin
          if (wr_q == last_idx) state_d = StHeader;
          else                  wr_d    = wr_q + 6'd1;
        end
      end
      StHeader: begin
        if (!bus.busy) begin
          par_d   = DATA_W'(hdr);
          rd_d    = '0;
          state_d = StPayload;
        end
      end
      StPayload: begin
        if (!bus.busy) begin
          par_d = par_q ^ mem_q[rd_q];
          if (rd_q == last_idx) state_d = StParity;
          else                  rd_d    = rd_q + 6'd1;
        end
      end
      StParity: begin
        if (!bus.busy) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (bus.abort) begin
      state_d = StIdle;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      dest_q  <= '0;
      len_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      par_q   <= '0;
      err_q   <= 1'b0;
`ifdef ROUTER_TX_PARITY_INJ_EN
      inj_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      dest_q  <= dest_d;
      len_q   <= len_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      par_q   <= par_d;
      err_q   <= err_d;
`ifdef ROUTER_TX_PARITY_INJ_EN
      inj_q   <= inj_d;
`endif
    end
  end

  // Payload storage needs no reset; it is always written before it is read.
  always_ff @(posedge clk) begin
    if (state_q == StLoad && bus.pl_valid) mem_q[wr_q] <= bus.pl_data;
  end

  always_comb begin
    data_out = '0;
    unique case (state_q)
      StHeader:  data_out = DATA_W'(hdr);
      StPayload: data_out = mem_q[rd_q];
      StParity:  data_out = par_out;
      default:   data_out = '0;
    endcase
  end

  assign bus.data_out  = data_out;
  assign bus.pkt_valid = (state_q == StHeader) || (state_q == StPayload);
  assign bus.pl_ready  = (state_q == StLoad);
  assign bus.tx_busy   = (state_q != StIdle);
  assign bus.done      = (state_q == StDone);
  assign bus.err       = err_q;
endmodule

// File: tb/tb_router_pkt_tx.sv
// Bench for router_pkt_tx: directed scenarios plus randomized packets, checked by a queue scoreboard.
module tb_router_pkt_tx;
  typedef struct packed {
    logic       is_done;
    logic       pv;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];
  logic [7:0] pl_buf [64];
  bit   rand_busy = 1'b0;
  bit   hold_mode = 1'b0;
  int   hold_cnt  = 0;
  int   seen22    = 0;
  int   pv_cnt    = 0;

  router_pkt_tx_if #(.DATA_W(8)) bus ();

  router_pkt_tx #(.DATA_W(8), .MAX_LEN(63)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Router-side busy driver; also counts presented-valid cycles.
  initial begin
    bus.busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (hold_mode && bus.pkt_valid && bus.data_out == 8'h22 && hold_cnt < 2) begin
        bus.busy = 1'b1;
        hold_cnt++;
      end else if (rand_busy) begin
        bus.busy = ($urandom_range(0, 3) == 0);
      end else begin
        bus.busy = 1'b0;
      end
      if (bus.pkt_valid && bus.data_out == 8'h22) seen22++;
      if (bus.pkt_valid) pv_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Reference: header {len,dest}, payload bytes, then XOR of all of them, then a done pulse.
  task automatic push_expected(input logic [1:0] d, input logic [5:0] l, input logic inj);
    logic [7:0] hdr;
    logic [7:0] p;
    hdr = {l, d};
    p   = hdr;
    exp_q.push_back('{is_done: 1'b0, pv: 1'b1, data: hdr});
    for (int i = 0; i < int'(l); i++) begin
      exp_q.push_back('{is_done: 1'b0, pv: 1'b1, data: pl_buf[i]});
      p = p ^ pl_buf[i];
    end
    if (inj) p = p ^ 8'h01;
    exp_q.push_back('{is_done: 1'b0, pv: 1'b0, data: p});
    exp_q.push_back('{is_done: 1'b1, pv: 1'b0, data: 8'h00});
  endtask

  task automatic start_and_load(input logic [1:0] d, input logic [5:0] l, input logic inj,
                                input bit rand_valid);
    int idx;
    int guard;
    bit v;
    bus.start = 1'b1;
    bus.dest  = d;
    bus.len   = l;
`ifdef ROUTER_TX_PARITY_INJ_EN
    bus.inj_parity_err = inj;
`endif
    tick();
    bus.start = 1'b0;
    bus.dest  = 2'($urandom);
    bus.len   = 6'($urandom);
    chk("accept_pl_ready", 32'(bus.pl_ready), 32'd1);
    chk("accept_tx_busy", 32'(bus.tx_busy), 32'd1);
    push_expected(d, l, inj);
    idx   = 0;
    guard = 0;
    while (idx < int'(l) && guard < 1000) begin
      v = rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.pl_valid = v;
      bus.pl_data  = v ? pl_buf[idx] : 8'($urandom);
      tick();
      guard++;
      if (v) idx++;
    end
    bus.pl_valid = 1'b0;
    chk("load_complete", 32'(idx), 32'(l));
    chk("pl_ready_drop", 32'(bus.pl_ready), 32'd0);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (bus.done !== 1'b1 && n < 3000) begin
      tick();
      n++;
    end
    chk("done_seen", 32'(bus.done), 32'd1);
    tick();
    chk("done_one_cycle", 32'(bus.done), 32'd0);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic run_all();
    int pv0;
    int s0;
    logic [1:0] d;
    logic [5:0] l;
    logic inj;
    bus.start = 1'b0; bus.dest = '0; bus.len = '0; bus.abort = 1'b0;
    bus.pl_data = '0; bus.pl_valid = 1'b0;
`ifdef ROUTER_TX_PARITY_INJ_EN
    bus.inj_parity_err = 1'b0;
`endif
    rst = 1'b0;
    tick();
    tick();
    chk("rst_data_out", 32'(bus.data_out), 32'd0);
    chk("rst_pkt_valid", 32'(bus.pkt_valid), 32'd0);
    chk("rst_pl_ready", 32'(bus.pl_ready), 32'd0);
    chk("rst_tx_busy", 32'(bus.tx_busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    rst = 1'b1;
    tick();

    // Basic packet, then the same packet with a two-cycle stall on byte 22.
    pl_buf[0] = 8'h11; pl_buf[1] = 8'h22; pl_buf[2] = 8'h33;
    pv0 = pv_cnt;
    start_and_load(2'd0, 6'd3, 1'b0, 1'b0);
    wait_done();
    chk("t1_valid_cycles", 32'(pv_cnt - pv0), 32'd4);
    hold_mode = 1'b1;
    pv0 = pv_cnt;
    s0  = seen22;
    start_and_load(2'd0, 6'd3, 1'b0, 1'b0);
    wait_done();
    hold_mode = 1'b0;
    chk("t2_hold_22", 32'(seen22 - s0), 32'd3);
    chk("t2_valid_cycles", 32'(pv_cnt - pv0), 32'd6);

    // Illegal starts.
    for (int k = 0; k < 2; k++) begin
      bus.start = 1'b1;
      bus.dest  = (k == 0) ? 2'd3 : 2'd1;
      bus.len   = (k == 0) ? 6'd5 : 6'd0;
      tick();
      bus.start = 1'b0;
      chk("illegal_err", 32'(bus.err), 32'd1);
      chk("illegal_pl_ready", 32'(bus.pl_ready), 32'd0);
      chk("illegal_tx_busy", 32'(bus.tx_busy), 32'd0);
      chk("illegal_pkt_valid", 32'(bus.pkt_valid), 32'd0);
      tick();
      chk("illegal_err_pulse", 32'(bus.err), 32'd0);
    end

    // Maximum length, followed immediately by a one-byte packet.
    for (int i = 0; i < 63; i++) pl_buf[i] = 8'(i);
    pv0 = pv_cnt;
    start_and_load(2'd1, 6'd63, 1'b0, 1'b0);
    wait_done();
    chk("t4_valid_cycles", 32'(pv_cnt - pv0), 32'd64);
    pl_buf[0] = 8'($urandom);
    start_and_load(2'd2, 6'd1, 1'b0, 1'b0);
    wait_done();

    // Start ignored mid-payload, then asynchronous reset between edges.
    for (int i = 0; i < 8; i++) pl_buf[i] = 8'($urandom);
    start_and_load(2'd2, 6'd8, 1'b0, 1'b0);
    tick();
    tick();
    bus.start = 1'b1; bus.dest = 2'd1; bus.len = 6'd2;
    tick();
    bus.start = 1'b0;
    chk("mid_start_tx_busy", 32'(bus.tx_busy), 32'd1);
    chk("mid_start_pkt_valid", 32'(bus.pkt_valid), 32'd1);
    chk("mid_start_pl_ready", 32'(bus.pl_ready), 32'd0);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_outputs",
        32'({bus.data_out, bus.pkt_valid, bus.pl_ready, bus.tx_busy, bus.done, bus.err}), 32'd0);
    exp_q.delete();
    tick();
    rst = 1'b1;
    tick();

    // Abort while the header is presented.
    for (int i = 0; i < 4; i++) pl_buf[i] = 8'($urandom);
    start_and_load(2'd0, 6'd4, 1'b0, 1'b0);
    chk("pre_abort_pkt_valid", 32'(bus.pkt_valid), 32'd1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort_pkt_valid", 32'(bus.pkt_valid), 32'd0);
    chk("abort_tx_busy", 32'(bus.tx_busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    exp_q.delete();
    tick();

    // Randomized packets with random upstream gaps and router stalls.
    rand_busy = 1'b1;
    for (int k = 0; k < 25; k++) begin
      d = 2'($urandom_range(0, 2));
      l = (k < 8) ? 6'($urandom_range(1, 4)) : 6'($urandom_range(1, 63));
      for (int i = 0; i < int'(l); i++) pl_buf[i] = 8'($urandom);
`ifdef ROUTER_TX_PARITY_INJ_EN
      inj = 1'($urandom);
`else
      inj = 1'b0;
`endif
      start_and_load(d, l, inj, 1'b1);
      wait_done();
    end
    rand_busy = 1'b0;
    tick();

`ifdef ROUTER_TX_PARITY_INJ_EN
    pl_buf[0] = 8'h11; pl_buf[1] = 8'h22; pl_buf[2] = 8'h33;
    start_and_load(2'd0, 6'd3, 1'b1, 1'b0);
    wait_done();
`endif
  endtask

  initial begin
    exp_t e;
    logic [9:0] got;
    fork
      begin : monitor
        forever begin
          @(negedge clk);
          if (rst && (bus.done || (bus.tx_busy && !bus.pl_ready && !bus.busy))) begin
            got = {bus.done, bus.pkt_valid, bus.data_out};
            if (exp_q.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL unexpected_output got=%0h expected=none", got);
            end else begin
              e = exp_q.pop_front();
              chk("tx_byte", 32'(got), 32'(e));
            end
          end
        end
      end
      begin : stimulus
        run_all();
      end
    join_any
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
